// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch/decode front end: default widths,
// opcode values and the fetch FSM state encoding.
package instruction_fetch_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;
    localparam int OPC_W_DEF  = 3;

    localparam logic [2:0] OPC_HLT  = 3'b000;
    localparam logic [2:0] OPC_SKZ  = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_ANDD = 3'b011;
    localparam logic [2:0] OPC_XORR = 3'b100;
    localparam logic [2:0] OPC_LDA  = 3'b101;
    localparam logic [2:0] OPC_STO  = 3'b110;
    localparam logic [2:0] OPC_JMP  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_HI = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_DECODE   = 3'd3,
        ST_ISSUE    = 3'd4,
        ST_BRANCH   = 3'd5,
        ST_HALT     = 3'd6
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch/decode front end: reads a 16-bit instruction as two bytes, decodes the
// opcode, resolves JMP/SKZ/HLT locally and hands the rest to the execute unit.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              load_pc,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic              acc_zero,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OPC_W-1:0]  opcode,
    output logic [ADDR_W-1:0] operand,
    output logic              halted
);

    localparam int INSTR_W = 2 * DATA_W;

    fetch_state_t         state_reg, state_next;
    logic [INSTR_W-1:0]   instr_reg;
    logic [ADDR_W-1:0]    ir_addr_reg;

    assign opcode   = instr_reg[INSTR_W-1 -: OPC_W];
    assign operand  = instr_reg[ADDR_W-1:0];
    assign ir_addr  = ir_addr_reg;
    // Address bus is quiet outside fetch states so reset drives it to zero.
    assign mem_addr = mem_rd ? pc_addr : '0;

    always_comb begin
        state_next = state_reg;
        pc_inc     = 1'b0;
        load_pc    = 1'b0;
        mem_rd     = 1'b0;
        ex_valid   = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH_HI;
            ST_FETCH_HI: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    pc_inc     = 1'b1;
                    state_next = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    pc_inc     = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_HLT: state_next = ST_HALT;
                    OPC_JMP: state_next = ST_BRANCH;
                    OPC_SKZ: state_next = acc_zero ? ST_BRANCH : ST_FETCH_HI;
                    default: state_next = ST_ISSUE;
                endcase
            end
            ST_ISSUE: begin
                ex_valid = 1'b1;
                if (ex_ready) state_next = ST_FETCH_HI;
            end
            ST_BRANCH: begin
                load_pc    = 1'b1;
                state_next = ST_FETCH_HI;
            end
            ST_HALT: halted = 1'b1;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            instr_reg   <= '0;
            ir_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH_HI && mem_ready)
                instr_reg[INSTR_W-1:DATA_W] <= mem_data;
            if (state_reg == ST_FETCH_LO && mem_ready)
                instr_reg[DATA_W-1:0] <= mem_data;
            // PC has already stepped past both bytes here, so +2 skips the next instruction.
            if (state_reg == ST_DECODE) begin
                if (opcode == OPC_JMP)
                    ir_addr_reg <= operand;
                else if (opcode == OPC_SKZ && acc_zero)
                    ir_addr_reg <= pc_addr + ADDR_W'(2);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: models the PC and a byte memory,
// walks a short program and checks outputs on the falling clock edge.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] pc_addr;
    logic        pc_inc, load_pc, mem_rd, ex_valid, halted;
    logic [12:0] ir_addr, mem_addr, operand;
    logic [2:0]  opcode;
    logic        mem_ready, acc_zero, ex_ready;
    wire  [7:0]  mem_data;
    logic [7:0]  mem [0:8191];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Junk byte when not ready, so any stray capture shows up in the instruction.
    assign mem_data = mem_ready ? mem[pc_addr] : 8'hA5;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_inc(pc_inc),
        .load_pc(load_pc), .ir_addr(ir_addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready), .acc_zero(acc_zero),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .opcode(opcode),
        .operand(operand), .halted(halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the external PC follows load_pc / pc_inc of the current cycle.
    task automatic adv();
        logic        li, pi;
        logic [12:0] ia;
        #1;
        li = load_pc; pi = pc_inc; ia = ir_addr;
        @(posedge clk);
        #1;
        if (li) pc_addr = ia;
        else if (pi) pc_addr = pc_addr + 13'd1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pc_addr = 13'h0; mem_ready = 1'b1; ex_ready = 1'b0; acc_zero = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0000] = 8'hE1; mem[13'h0001] = 8'h23;   // JMP 0x0123
        mem[13'h0123] = 8'hE0; mem[13'h0124] = 8'h10;   // JMP 0x0010
        mem[13'h0010] = 8'h20; mem[13'h0011] = 8'h00;   // SKZ (taken)
        mem[13'h0014] = 8'h20; mem[13'h0015] = 8'h00;   // SKZ (not taken)
        mem[13'h0016] = 8'h40; mem[13'h0017] = 8'h55;   // ADD 0x0055
        mem[13'h0018] = 8'hFF; mem[13'h0019] = 8'hFC;   // JMP 0x1FFC
        mem[13'h1FFC] = 8'h20; mem[13'h1FFD] = 8'h00;   // SKZ (taken, wraps)

        repeat (2) @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ir_addr", ir_addr, 0);

        // Start a fetch, then reset during FETCH_LO.
        rst_n = 1'b1;
        #1 chk("idle_mem_rd", mem_rd, 0);
        adv();
        chk("fh0_mem_rd", mem_rd, 1);
        chk("fh0_pc_inc", pc_inc, 1);
        adv();
        chk("fl0_mem_addr", mem_addr, 13'h0001);
        chk("fl0_opcode", opcode, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_rd", mem_rd, 0);
        chk("mid_rst_pc_inc", pc_inc, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_opcode", opcode, 0);
        chk("mid_rst_operand", operand, 0);
        chk("mid_rst_load_pc", load_pc, 0);
        chk("mid_rst_ex_valid", ex_valid, 0);
        $display("txn reset mid-fetch");
        pc_addr = 13'h0;
        adv();
        rst_n = 1'b1;
        #1 chk("idle2_mem_rd", mem_rd, 0);

        // JMP 16'hE123
        adv();
        chk("jmp_fh_mem_rd", mem_rd, 1);
        chk("jmp_fh_mem_addr", mem_addr, 13'h0000);
        chk("jmp_fh_pc_inc", pc_inc, 1);
        adv();
        chk("jmp_fl_pc_inc", pc_inc, 1);
        adv();
        chk("jmp_dec_pc_inc", pc_inc, 0);
        chk("jmp_dec_load_pc", load_pc, 0);
        chk("jmp_dec_operand", operand, 13'h0123);
        adv();
        chk("jmp_br_load_pc", load_pc, 1);
        chk("jmp_br_pc_inc", pc_inc, 0);
        chk("jmp_br_ir_addr", ir_addr, 13'h0123);
        adv();
        chk("jmp_next_load_pc", load_pc, 0);
        chk("jmp_next_mem_addr", mem_addr, 13'h0123);
        $display("txn JMP 0x0123");

        // JMP 0x0010
        repeat (3) adv();
        chk("jmp2_ir_addr", ir_addr, 13'h0010);
        acc_zero = 1'b1;
        adv();
        chk("skz1_fh_mem_addr", mem_addr, 13'h0010);

        // SKZ at 0x0010 with acc_zero=1 -> 0x0014
        repeat (2) adv();
        chk("skz1_dec_opcode", opcode, 3'b001);
        adv();
        chk("skz1_br_load_pc", load_pc, 1);
        chk("skz1_br_ir_addr", ir_addr, 13'h0014);
        acc_zero = 1'b0;
        adv();
        chk("skz2_fh_mem_addr", mem_addr, 13'h0014);
        $display("txn SKZ taken -> 0x0014");

        // SKZ at 0x0014 with acc_zero=0 -> straight to next fetch
        repeat (3) adv();
        chk("skz2_load_pc", load_pc, 0);
        chk("skz2_mem_rd", mem_rd, 1);
        chk("skz2_mem_addr", mem_addr, 13'h0016);
        chk("skz2_ir_addr_kept", ir_addr, 13'h0014);
        $display("txn SKZ not taken");

        // ADD 16'h4055 with ex_ready low for 3 cycles
        repeat (3) adv();
        for (int i = 0; i < 3; i++) begin
            chk("add_ex_valid", ex_valid, 1);
            chk("add_opcode", opcode, 3'b010);
            chk("add_operand", operand, 13'h0055);
            chk("add_mem_rd", mem_rd, 0);
            if (i < 2) adv();
        end
        ex_ready = 1'b1;
        adv();
        ex_ready = 1'b0;
        chk("add_after_ex_valid", ex_valid, 0);
        chk("add_after_mem_addr", mem_addr, 13'h0018);
        $display("txn ADD 0x0055 accepted");

        // Memory stall: mem_ready low for 5 cycles in FETCH_HI
        mem_ready = 1'b0;
        #1 chk("stall_pc_inc0", pc_inc, 0);
        for (int i = 0; i < 5; i++) begin
            adv();
            chk("stall_mem_rd", mem_rd, 1);
            chk("stall_pc_inc", pc_inc, 0);
            chk("stall_mem_addr", mem_addr, 13'h0018);
            chk("stall_opcode", opcode, 3'b010);
            chk("stall_operand", operand, 13'h0055);
        end
        mem_ready = 1'b1;
        #1 chk("stall_end_pc_inc", pc_inc, 1);
        adv();
        chk("stall_fl_opcode", opcode, 3'b111);
        chk("stall_fl_mem_addr", mem_addr, 13'h0019);
        adv();
        chk("stall_dec_operand", operand, 13'h1FFC);
        adv();
        chk("jmp3_ir_addr", ir_addr, 13'h1FFC);
        $display("txn stalled JMP 0x1FFC");
        acc_zero = 1'b1;
        mem[13'h0000] = 8'h00; mem[13'h0001] = 8'h00;   // HLT at the wrap target
        adv();
        chk("wrap_fh_mem_addr", mem_addr, 13'h1FFC);

        // SKZ fetched from 0x1FFC: PC is 0x1FFE in DECODE, target wraps to 0
        repeat (2) adv();
        chk("wrap_dec_opcode", opcode, 3'b001);
        adv();
        chk("wrap_br_load_pc", load_pc, 1);
        chk("wrap_br_ir_addr", ir_addr, 13'h0000);
        adv();
        chk("wrap_next_mem_addr", mem_addr, 13'h0000);
        $display("txn SKZ wrap -> 0x0000");

        // HLT 16'h0000
        repeat (2) adv();
        chk("hlt_dec_opcode", opcode, 3'b000);
        adv();
        for (int i = 0; i < 4; i++) begin
            chk("hlt_halted", halted, 1);
            chk("hlt_mem_rd", mem_rd, 0);
            chk("hlt_pc_inc", pc_inc, 0);
            chk("hlt_load_pc", load_pc, 0);
            chk("hlt_ex_valid", ex_valid, 0);
            adv();
        end
        $display("txn HLT");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
